// File: rtl/adder_bist_checker.sv
// adder_bist_checker: built-in self-test engine for a WIDTH-bit full adder.
// Sweeps every {c_in,b,a} vector into the adder and holds it for SETTLE cycles.
// It then samples {c_out,sum} and compares that pair against a golden add.
// Mismatches are counted in a saturating counter, and the first failing index is recorded.
// Optional build macro: ADDER_BIST_STOP_ON_FAIL_EN. When defined, the sweep ends on the
// first mismatch, and the failing vector stays on the adder pins so it can be probed.
module adder_bist_checker #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1,
  parameter int ERR_W  = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [WIDTH-1:0]   dut_a,
  output logic [WIDTH-1:0]   dut_b,
  output logic               dut_c_in,
  input  logic [WIDTH-1:0]   dut_sum,
  input  logic               dut_c_out,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ERR_W-1:0]   err_count,
  output logic [2*WIDTH:0]   first_fail_vec
);

  localparam int IDX_W = 2*WIDTH+1;
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE-1);
  localparam logic [IDX_W-1:0] IDX_MAX  = {IDX_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Reference result for the adder under test, one bit wider to keep the carry.
  function automatic logic [WIDTH:0] golden_add(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic             c);
    return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
  endfunction

  state_t             state_r, state_s;
  logic [IDX_W-1:0]   idx_r, idx_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [ERR_W-1:0]   err_r, err_s;
  logic [IDX_W-1:0]   ffv_r, ffv_s;
  logic               busy_r, busy_s;
  logic               done_r, done_s;
  logic               pass_r, pass_s;
  logic               mismatch_s;
  logic [ERR_W-1:0]   err_upd_s;
  logic               stop_s;

  // The vector index register drives the adder pins directly, so they are flop outputs.
  assign dut_a          = idx_r[WIDTH-1:0];
  assign dut_b          = idx_r[2*WIDTH-1:WIDTH];
  assign dut_c_in       = idx_r[2*WIDTH];
  assign busy           = busy_r;
  assign done           = done_r;
  assign pass           = pass_r;
  assign err_count      = err_r;
  assign first_fail_vec = ffv_r;

  // Compare the adder response against the golden sum for the applied vector.
  always_comb begin
    mismatch_s = ({dut_c_out, dut_sum} != golden_add(dut_a, dut_b, dut_c_in));
  end

  // Next-state logic and next values for the sweep bookkeeping.
  always_comb begin
    state_s   = state_r;
    idx_s     = idx_r;
    cnt_s     = cnt_r;
    err_s     = err_r;
    ffv_s     = ffv_r;
    busy_s    = busy_r;
    done_s    = done_r;
    pass_s    = pass_r;
    err_upd_s = err_r;
    stop_s    = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_s = ST_APPLY;
          idx_s   = {IDX_W{1'b0}};
          cnt_s   = {CNT_W{1'b0}};
          err_s   = {ERR_W{1'b0}};
          ffv_s   = {IDX_W{1'b0}};
          busy_s  = 1'b1;
          done_s  = 1'b0;
          pass_s  = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      ST_APPLY: begin
        if (cnt_r == CNT_LAST) begin
          state_s = ST_CHECK;
          cnt_s   = {CNT_W{1'b0}};
        end else begin
          cnt_s   = cnt_r + CNT_W'(1);
        end
      end
      ST_CHECK: begin
        if (mismatch_s) begin
          if (err_r != ERR_MAX) begin
            err_upd_s = err_r + ERR_W'(1);
          end else begin
            err_upd_s = err_r;
          end
          if (err_r == {ERR_W{1'b0}}) begin
            ffv_s = idx_r;
          end else begin
            ffv_s = ffv_r;
          end
        end else begin
          err_upd_s = err_r;
        end
        err_s = err_upd_s;
`ifdef ADDER_BIST_STOP_ON_FAIL_EN
        stop_s = (idx_r == IDX_MAX) || mismatch_s;
`else
        stop_s = (idx_r == IDX_MAX);
`endif
        if (stop_s) begin
          state_s = ST_DONE;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          pass_s  = (err_upd_s == {ERR_W{1'b0}});
        end else begin
          state_s = ST_APPLY;
          idx_s   = idx_r + IDX_W'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and result registers; reset returns everything to idle with zeroed outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      idx_r   <= {IDX_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      err_r   <= {ERR_W{1'b0}};
      ffv_r   <= {IDX_W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      cnt_r   <= cnt_s;
      err_r   <= err_s;
      ffv_r   <= ffv_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      pass_r  <= pass_s;
    end
  end

endmodule

// File: tb/tb_adder_bist_checker.sv
// Bench for adder_bist_checker. It drives a behavioural adder with selectable stuck-at faults.
// Expected sweep results come from an independent integer model of the whole vector space.
// They are queued when start is issued and compared when done rises.
module tb_adder_bist_checker;

  localparam int WIDTH = 4;
  localparam int ERR_W = 10;
  localparam int NVEC  = 512;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] dut_a;
  logic [WIDTH-1:0] dut_b;
  logic             dut_c_in;
  logic [WIDTH-1:0] dut_sum;
  logic             dut_c_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [2*WIDTH:0] first_fail_vec;

  int total;
  int bad;
  int fault_mode;

  typedef struct {
    int err;
    int ffv;
    int pass;
    int lat;
    int hold;
  } exp_t;

  exp_t sb[$];

  adder_bist_checker #(.WIDTH(WIDTH), .SETTLE(1), .ERR_W(ERR_W)) u_dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .dut_a          (dut_a),
    .dut_b          (dut_b),
    .dut_c_in       (dut_c_in),
    .dut_sum        (dut_sum),
    .dut_c_out      (dut_c_out),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_fail_vec (first_fail_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Adder under test with optional stuck-at faults: 1 = sum[0] stuck 0, 2 = c_out stuck 0.
  always_comb begin
    int s;
    s = int'(dut_a) + int'(dut_b) + int'(dut_c_in);
    dut_sum   = s[3:0];
    dut_c_out = s[4];
    if (fault_mode == 1) dut_sum[0] = 1'b0;
    if (fault_mode == 2) dut_c_out = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input int fm);
    exp_t e;
    e.err = 0; e.ffv = 0; e.lat = NVEC * 2; e.hold = NVEC - 1;
    for (int i = 0; i < NVEC; i++) begin
      int a, b, c, s, f;
      a = i % 16; b = (i / 16) % 16; c = i / 256;
      s = a + b + c;
      f = s;
      if (fm == 1) f = s - (s % 2);
      if (fm == 2) f = s % 16;
      if (f != s) begin
        if (e.err == 0) e.ffv = i;
        e.err++;
`ifdef ADDER_BIST_STOP_ON_FAIL_EN
        e.lat  = (i + 1) * 2;
        e.hold = i;
        break;
`endif
      end
    end
    e.pass = (e.err == 0) ? 1 : 0;
    return e;
  endfunction

  // One sweep: optional ignored start at cycle mid_start, optional reset at cycle abort_at.
  task automatic run_sweep(input int fm, input int mid_start, input int abort_at);
    exp_t e;
    exp_t got;
    int cyc;
    fault_mode = fm;
    e = model(fm);
    @(negedge clk);
    start = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_on_start", busy, 1);
    chk("done_cleared_on_start", done, 0);
    chk("pass_cleared_on_start", pass, 0);
    chk("err_cleared_on_start", err_count, 0);
    chk("first_vec_applied", {dut_c_in, dut_b, dut_a}, 0);
    cyc = 0;
    while (cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
      start = (cyc == mid_start) ? 1'b1 : 1'b0;
      if (cyc == abort_at) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_err", err_count, 0);
        chk("abort_ffv", first_fail_vec, 0);
        chk("abort_dut", {dut_c_in, dut_b, dut_a}, 0);
        void'(sb.pop_front());
        return;
      end
      if (done) break;
    end
    start = 1'b0;
    got = sb.pop_front();
    chk("done_latency", cyc, got.lat);
    chk("err_count", err_count, got.err);
    chk("first_fail_vec", first_fail_vec, got.ffv);
    chk("pass", pass, got.pass);
    chk("busy_at_done", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("done_held", done, 1);
    chk("dut_hold", {dut_c_in, dut_b, dut_a}, got.hold);
  endtask

  initial begin
    total = 0;
    bad = 0;
    fault_mode = 0;
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst_ffv", first_fail_vec, 0);
    chk("rst_dut", {dut_c_in, dut_b, dut_a}, 0);
    start = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_no_start", busy, 0);

    run_sweep(0, -1, -1);   // clean adder
    run_sweep(1, -1, -1);   // sum[0] stuck-at-0
    run_sweep(2, -1, -1);   // c_out stuck-at-0
    run_sweep(1, -1, 300);  // reset mid-sweep
    run_sweep(0, -1, -1);   // clean sweep after the aborted one
    run_sweep(0, 500, -1);  // start while busy must be ignored
    run_sweep(1, -1, -1);   // restart from DONE

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
